// File: rtl/reg_file_wb.sv
// reg_file_wb: one-entry writeback stage in front of an 8 x 32 register file
// and CPSR. A captured entry commits on the following edge. Until then it
// forwards combinationally to both read ports and to the flags output.
module reg_file_wb #(
    parameter  int DATA_W  = 32,
    parameter  int NREGS   = 8,
    parameter  int FLAGS_W = 4,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      r_sel_0,
    input  logic [AW-1:0]      r_sel_1,
    output logic [DATA_W-1:0]  r_val_0,
    output logic [DATA_W-1:0]  r_val_1,
    input  logic [AW-1:0]      w_reg,
    input  logic [DATA_W-1:0]  w_alu,
    input  logic [DATA_W-1:0]  w_id,
    input  logic               w_enable,
    input  logic               w_select,
    input  logic [1:0]         w_half,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic               flags_we,
    input  logic               stall,
    output logic [FLAGS_W-1:0] flags,
    output logic               wb_valid
);
    localparam int HW = DATA_W / 2;

    // Architectural state
    logic [DATA_W-1:0]  r_regs [NREGS];
    logic [FLAGS_W-1:0] r_cpsr;

    // Writeback entry (stage p1)
    logic               r_vld_p1;
    logic [AW-1:0]      r_reg_p1;
    logic [DATA_W-1:0]  r_data_p1;
    logic [1:0]         r_half_p1;
    logic               r_fwe_p1;
    logic [FLAGS_W-1:0] r_flags_p1;

    logic               w_capture;

    // Overlay the pending entry's enabled halves onto the stored register.
    function automatic logic [DATA_W-1:0] fwd_read(input logic [AW-1:0] sel);
        logic [DATA_W-1:0] v;
        v = r_regs[sel];
        if (r_vld_p1 && (r_reg_p1 == sel)) begin
            if (r_half_p1[1]) v[DATA_W-1:HW] = r_data_p1[DATA_W-1:HW];
            if (r_half_p1[0]) v[HW-1:0]      = r_data_p1[HW-1:0];
        end
        return v;
    endfunction

    assign w_capture = !stall && (w_enable || flags_we);

    // Entry valid: cleared by reset so a pending entry is dropped uncommitted.
    always_ff @(posedge clk) begin
        if (rst) r_vld_p1 <= 1'b0;
        else     r_vld_p1 <= w_capture;
    end

    // Entry payload: only meaningful while r_vld_p1 is set, so it is not reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_reg_p1   <= w_reg;
            r_data_p1  <= w_select ? w_id : w_alu;
            r_half_p1  <= w_enable ? w_half : 2'b00;
            r_fwe_p1   <= flags_we;
            r_flags_p1 <= flags_in;
        end
    end

    // Commit the pending entry into the register file and CPSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_cpsr <= '0;
        end else if (r_vld_p1) begin
            if (r_half_p1[1]) r_regs[r_reg_p1][DATA_W-1:HW] <= r_data_p1[DATA_W-1:HW];
            if (r_half_p1[0]) r_regs[r_reg_p1][HW-1:0]      <= r_data_p1[HW-1:0];
            if (r_fwe_p1)     r_cpsr <= r_flags_p1;
        end
    end

    // Forwarded read ports and flags; only the latched entry forwards.
    always_comb begin
        r_val_0  = fwd_read(r_sel_0);
        r_val_1  = fwd_read(r_sel_1);
        flags    = (r_vld_p1 && r_fwe_p1) ? r_flags_p1 : r_cpsr;
        wb_valid = r_vld_p1;
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: the stimulus pushes expected outputs for
// the current cycle, and a monitor pops and compares them on the falling edge.
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r_sel_0, r_sel_1, w_reg;
    logic [31:0] r_val_0, r_val_1, w_alu, w_id;
    logic        w_enable, w_select, flags_we, stall, wb_valid;
    logic [1:0]  w_half;
    logic [3:0]  flags_in, flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          port;   // 0 r_val_0, 1 r_val_1, 2 flags, 3 wb_valid
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    reg_file_wb dut (
        .clk(clk), .rst(rst),
        .r_sel_0(r_sel_0), .r_sel_1(r_sel_1),
        .r_val_0(r_val_0), .r_val_1(r_val_1),
        .w_reg(w_reg), .w_alu(w_alu), .w_id(w_id),
        .w_enable(w_enable), .w_select(w_select), .w_half(w_half),
        .flags_in(flags_in), .flags_we(flags_we), .stall(stall),
        .flags(flags), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_enable = 0; flags_we = 0; w_select = 0; w_half = 2'b00;
        w_reg = 0; w_alu = 0; w_id = 0; flags_in = 0; stall = 0;
    endtask

    task automatic wr_alu(input logic [2:0] r, input logic [31:0] d);
        w_enable = 1; w_select = 0; w_half = 2'b11; w_reg = r; w_alu = d;
    endtask

    task automatic exp_out(input string n, input int p, input logic [31:0] v);
        exp_t e;
        e.name = n; e.port = p; e.exp = v;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every expectation queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.port)
                    0:       act = r_val_0;
                    1:       act = r_val_1;
                    2:       act = {28'd0, flags};
                    default: act = {31'd0, wb_valid};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; r_sel_0 = 0; r_sel_1 = 0;
        idle();
        tick();
        tick();
        exp_out("reset_rval0", 0, 32'h0);
        exp_out("reset_rval1", 1, 32'h0);
        exp_out("reset_flags", 2, 32'h0);
        exp_out("reset_wbv",   3, 32'h0);

        // Basic writeback r3
        rst = 0;
        wr_alu(3, 32'hDEADBEEF);
        tick();
        idle(); r_sel_0 = 3;
        exp_out("basic_fwd",     0, 32'hDEADBEEF);
        exp_out("basic_wbv1",    3, 32'h1);
        tick();
        exp_out("basic_commit",  0, 32'hDEADBEEF);
        exp_out("basic_wbv0",    3, 32'h0);

        // MOV / MOVT merge on r5
        w_enable = 1; w_select = 1; w_id = 32'h00001234; w_half = 2'b01; w_reg = 5;
        tick();
        r_sel_1 = 5;
        exp_out("mov_fwd", 1, 32'h00001234);
        w_id = 32'hABCD0000; w_half = 2'b10;
        tick();
        exp_out("movt_fwd", 1, 32'hABCD1234);
        idle();
        tick();
        exp_out("movt_commit", 1, 32'hABCD1234);
        exp_out("movt_r3_kept", 0, 32'hDEADBEEF);

        // Flags-only update, then register write without flags
        flags_we = 1; flags_in = 4'b1010;
        tick();
        exp_out("flags_fwd",  2, 32'hA);
        exp_out("flags_wbv",  3, 32'h1);
        idle(); wr_alu(6, 32'h77);
        tick();
        r_sel_0 = 5;
        exp_out("flags_commit",  2, 32'hA);
        exp_out("flags_noreg",   0, 32'hABCD1234);
        idle();
        tick();
        r_sel_0 = 6;
        exp_out("flags_kept",    2, 32'hA);
        exp_out("r6_commit",     0, 32'h77);

        // Stall
        wr_alu(2, 32'h11);
        tick();
        r_sel_0 = 2;
        exp_out("stall_pre_fwd", 0, 32'h11);
        stall = 1; wr_alu(2, 32'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_out("stall_r2",  0, 32'h11);
            exp_out("stall_wbv", 3, 32'h0);
        end
        stall = 0;
        tick();
        exp_out("unstall_fwd", 0, 32'h22);
        exp_out("unstall_wbv", 3, 32'h1);
        idle();
        tick();
        exp_out("unstall_commit", 0, 32'h22);

        // Reset mid-operation
        wr_alu(7, 32'h55); flags_we = 1; flags_in = 4'b1111;
        tick();
        r_sel_1 = 7;
        exp_out("rstmid_fwd",   1, 32'h55);
        exp_out("rstmid_flags", 2, 32'hF);
        idle(); rst = 1;
        tick();
        r_sel_0 = 6;
        exp_out("rstmid_r7",    1, 32'h0);
        exp_out("rstmid_fl0",   2, 32'h0);
        exp_out("rstmid_wbv",   3, 32'h0);
        exp_out("rstmid_r6",    0, 32'h0);
        rst = 0;

        // Back-to-back with dual read of r1
        r_sel_0 = 1; r_sel_1 = 1;
        wr_alu(1, 32'h1);
        tick();
        exp_out("b2b_p0_c1", 0, 32'h1);
        exp_out("b2b_p1_c1", 1, 32'h1);
        wr_alu(1, 32'h2);
        tick();
        exp_out("b2b_p0_c2", 0, 32'h2);
        exp_out("b2b_p1_c2", 1, 32'h2);
        wr_alu(4, 32'h3);
        tick();
        exp_out("b2b_p0_c3", 0, 32'h2);
        exp_out("b2b_p1_c3", 1, 32'h2);
        idle();
        tick();
        r_sel_1 = 4;
        exp_out("b2b_r1_final", 0, 32'h2);
        exp_out("b2b_r4_final", 1, 32'h3);

        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Writeback and register-file block at the far end of the execute-stage write interface.
- Accepts the execute result pair (ALU path and ID path), the write enable, the source select, the destination register and flag updates, and registers them in a one-entry writeback stage.
- Commits that entry to an 8 x 32-bit register file and the CPSR on the next cycle.
- Supplies forwarded operand values (r_val_0, r_val_1) and current CPSR flags back to execute.

Parameters:
- DATA_W, 32, register and data width.
- NREGS, 8, number of general registers; address width is 3 bits.
- FLAGS_W, 4, CPSR width, ordered N, C, Z, V (bit 3 down to bit 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- r_sel_0  input  3  read port 0 register index.
- r_sel_1  input  3  read port 1 register index.
- r_val_0  output  32  read port 0 data, forwarded.
- r_val_1  output  32  read port 1 data, forwarded.
- w_reg  input  3  destination register index.
- w_alu  input  32  ALU-path write data.
- w_id  input  32  ID-path write data.
- w_enable  input  1  write request, active high.
- w_select  input  1  data source: 0 = w_alu, 1 = w_id.
- w_half  input  2  half mask: bit1 = [31:16], bit0 = [15:0]; 11 = full, 01 = MOV low, 10 = MOVT high, 00 = no register write.
- flags_in  input  4  new N, C, Z, V.
- flags_we  input  1  CPSR update request.
- stall  input  1  blocks capture of new requests.
- flags  output  4  current CPSR, forwarded.
- wb_valid  output  1  writeback entry pending commit.

Behaviour:
- **Single clock, reset:** one clock (clk). Reset is synchronous and active-high (rst).
- **Reset values:** all registers 0x00000000, CPSR 4'b0000, wb_valid 0. Consequently r_val_0, r_val_1 and flags read 0 after reset.
- **Reset mid-operation:** any pending entry is discarded with no commit. Reset dominates stall and all requests.
- **Capture (edge N):** if !stall and (w_enable or flags_we), latch the following and set wb_valid = 1; otherwise wb_valid = 0 at edge N:
  - wb_reg = w_reg
  - wb_data = w_select ? w_id : w_alu
  - wb_half = w_enable ? w_half : 2'b00
  - wb_fwe = flags_we
  - wb_flags = flags_in
- **Commit (edge N+1, wb_valid = 1):**
  - regs[wb_reg][31:16] is written from wb_data when wb_half[1] = 1; regs[wb_reg][15:0] is written when wb_half[0] = 1. Unmasked halves are preserved.
  - CPSR = wb_flags when wb_fwe = 1.
- **Latency:** 2 edges from request to architectural state, with 0-cycle visibility through forwarding.
- **Throughput:** capture and commit occur on the same edge, so back-to-back requests sustain one per cycle.
- **Stall:** suppresses capture only. A pending entry still commits and drains; wb_valid drops to 0 afterwards. Inputs presented during stall are ignored, not queued.
- **Read forwarding (combinational):**
  - r_val_k = regs[r_sel_k], with each half replaced by wb_data's half when wb_valid and wb_reg == r_sel_k and the corresponding wb_half bit is set.
  - Both read ports may address the same register; both then return identical data.
- **Flags forwarding:** flags = (wb_valid and wb_fwe) ? wb_flags : CPSR.
- **Forwarding scope:** no forwarding from the current-cycle inputs; only the latched entry forwards.
- **Register 0:** ordinary, writable; it is not hardwired to zero.
- **w_half = 00 with w_enable = 1:** no register change. The flags update still occurs if flags_we = 1.
- **Out-of-range values:** w_reg and r_sel are 3 bits, so no out-of-range index exists.
- **Latches:** none; all state is flip-flop based.

Test Plan:
- **Reset and basic writeback:** hold rst 2 cycles, then w_enable=1, w_reg=3, w_select=0, w_alu=0xDEADBEEF, w_half=11 -> wb_valid=1 after edge 1; r_sel_0=3 returns 0xDEADBEEF immediately after edge 1 (forwarded) and after edge 2 (committed); wb_valid=0 after edge 2.
- **MOV then MOVT merge:**
  - Cycle A: w_select=1, w_id=0x00001234, w_half=01 on r5.
  - Cycle B: w_id=0xABCD0000, w_half=10 on r5.
  - Expected: r_val_1 (r_sel_1=5) reads 0x00001234 after A and 0xABCD1234 after B, in both forwarded and committed form.
- **Flags-only update:** w_enable=0, flags_we=1, flags_in=4'b1010 -> flags=4'b1010 one edge later; no register changes. Then w_enable=1, flags_we=0 -> flags stays 4'b1010.
- **Stall:**
  - Issue a write of 0x11 to r2, then assert stall with w_enable=1, w_reg=2, data 0x22 for 3 cycles.
  - Expected: r2 = 0x11 committed, wb_valid=0 during stall, and 0x22 is never written.
  - Deassert stall -> 0x22 appears one edge later.
- **Reset mid-operation:** capture a write of 0x55 to r7 and flags 4'b1111, then assert rst on the next edge -> r7 = 0, flags = 0, wb_valid = 0.
- **Back-to-back and dual read:** write r1=0x1, r1=0x2, r4=0x3 on consecutive cycles with r_sel_0=r_sel_1=1 -> both ports show 1, 2, 2 on successive cycles; final r1=0x2, r4=0x3.
